// File: rtl/scan_ctrl.sv
// Scan-chain sequencer: shifts a pattern in, optionally runs CAP_CYCLES functional
// clocks, shifts the captured response out and reports it on unload_data.
module scan_ctrl #(
  parameter int SHIFT_LEN  = 4,
  parameter int CAP_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 abort,
  input  logic [SHIFT_LEN-1:0] load_data,
  output logic                 busy,
  output logic                 done,
  output logic [SHIFT_LEN-1:0] unload_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    UNLOAD = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Six bits cover both SHIFT_LEN-1 (max 31) and CAP_CYCLES-1 (max 14) without wrapping.
  localparam logic [5:0] LAST_SHIFT = 6'(SHIFT_LEN - 1);
  localparam logic [5:0] LAST_RUN   = 6'(CAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [SHIFT_LEN-1:0] pat_q, pat_d;
  logic [SHIFT_LEN-1:0] cap_q, cap_d;
  logic [SHIFT_LEN-1:0] unload_q, unload_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic [SHIFT_LEN-1:0] samp;

  // Sample taken at the closing edge of the current shift cycle; first sample ends up in the MSB.
  assign samp = {cap_q[SHIFT_LEN-2:0], scan_out};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    pat_d     = pat_q;
    cap_d     = cap_q;
    unload_d  = unload_q;
    busy_d    = busy_q;
    done_d    = done_q;
    scan_en_d = scan_en_q;
    scan_in_d = scan_in_q;

    case (state_q)
      IDLE: begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
        if (start) begin
          state_d   = LOAD;
          mode_d    = mode;
          pat_d     = {load_data[SHIFT_LEN-2:0], 1'b0};
          cap_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          scan_en_d = 1'b1;
          scan_in_d = load_data[SHIFT_LEN-1];
        end
      end
      LOAD: begin
        cap_d     = samp;
        scan_in_d = pat_q[SHIFT_LEN-1];
        pat_d     = {pat_q[SHIFT_LEN-2:0], 1'b0};
        if (cnt_q == LAST_SHIFT) begin
          cnt_d     = '0;
          scan_en_d = 1'b0;
          scan_in_d = 1'b0;
          if (mode_q) begin
            state_d = RUN;
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            unload_d = samp;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      RUN: begin
        if (cnt_q == LAST_RUN) begin
          state_d   = UNLOAD;
          cnt_d     = '0;
          scan_en_d = 1'b1;
          scan_in_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      UNLOAD: begin
        cap_d = samp;
        if (cnt_q == LAST_SHIFT) begin
          state_d   = DONE;
          cnt_d     = '0;
          scan_en_d = 1'b0;
          done_d    = 1'b1;
          unload_d  = samp;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
      end
    endcase

    // Abort overrides whatever transition the active phase computed; the result is kept.
    if (abort && (state_q == LOAD || state_q == RUN || state_q == UNLOAD)) begin
      state_d   = IDLE;
      cnt_d     = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      scan_en_d = 1'b0;
      scan_in_d = 1'b0;
      unload_d  = unload_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      pat_q     <= '0;
      cap_q     <= '0;
      unload_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      cap_q     <= cap_d;
      unload_q  <= unload_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign unload_data = unload_q;
  assign scan_en     = scan_en_q;
  assign scan_in     = scan_in_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl (SHIFT_LEN=4, CAP_CYCLES=3) against a 4-bit chain model
// that shifts when scan_en is high and counts up during capture cycles.
module tb_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic       abort;
  logic [3:0] load_data;
  logic       busy;
  logic       done;
  logic [3:0] unload_data;
  logic       scan_en;
  logic       scan_in;
  logic       scan_out;
  logic [2:0] dbg_state;

  logic [3:0] c = 4'b0000;
  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;

  scan_ctrl #(.SHIFT_LEN(4), .CAP_CYCLES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .abort       (abort),
    .load_data   (load_data),
    .busy        (busy),
    .done        (done),
    .unload_data (unload_data),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .dbg_state   (dbg_state)
  );

  // Clock and chain model
  always #5 clk = ~clk;

  assign scan_out = c[3];

  always @(posedge clk) begin
    if (scan_en) c <= {c[2:0], scan_in};
    else if (busy && !done) c <= c + 4'd1;
  end

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation; checks the MSB-first pattern, capture length, latency and result.
  task automatic run_op(input logic m, input logic [3:0] d, input logic ab, input int exp_lat,
                        input logic [3:0] exp_unl, input string tag);
    int cyc;
    int run_cnt;
    @(negedge clk);
    start = 1'b1; mode = m; load_data = d; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    cyc = 0;
    run_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      check_eq({tag, "_load_en"}, scan_en, 1);
      check_eq({tag, "_load_in"}, scan_in, d[3-k]);
      @(negedge clk);
      cyc++;
    end
    while (!done && cyc < 40) begin
      if (busy && !scan_en) run_cnt++;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_latency"}, cyc, exp_lat);
    check_eq({tag, "_run_cycles"}, run_cnt, m ? 3 : 0);
    check_eq({tag, "_unload"}, unload_data, exp_unl);
    check_eq({tag, "_done_en"}, scan_en, 0);
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, busy, 0);
    check_eq({tag, "_idle_done"}, done, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; load_data = 4'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_en", scan_en, 0);
    check_eq("rst_in", scan_in, 0);
    check_eq("rst_unload", unload_data, 0);
    check_eq("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // Shift-only from a cleared chain
    run_op(1'b0, 4'b1011, 1'b0, 4, 4'b0000, "op1");
    check_eq("op1_chain", c, 4'b1011);

    // Shift-only with abort alongside start in IDLE: start wins
    run_op(1'b0, 4'b0110, 1'b1, 4, 4'b1011, "op2");
    check_eq("op2_chain", c, 4'b0110);

    // Load-capture-unload
    run_op(1'b1, 4'b0101, 1'b0, 11, 4'b1000, "op3");
    check_eq("op3_chain", c, 4'b0000);

    // Start pulses during LOAD and DONE are ignored
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; load_data = 4'b1110;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; load_data = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("ign_done", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("ign_busy_after_done", busy, 0);
    repeat (2) @(negedge clk);
    check_eq("ign_still_idle", busy, 0);
    check_eq("ign_done_pulses", done_cnt - base, 1);
    check_eq("ign_unload", unload_data, 4'b0000);
    check_eq("ign_chain", c, 4'b1110);

    // Abort in the second RUN cycle
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; load_data = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("abt_in_run", dbg_state, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abt_state", dbg_state, 0);
    check_eq("abt_busy", busy, 0);
    check_eq("abt_en", scan_en, 0);
    check_eq("abt_unload", unload_data, 4'b0000);
    repeat (3) @(negedge clk);
    check_eq("abt_no_done", done_cnt - base, 0);
    check_eq("abt_chain", c, 4'b0101);
    run_op(1'b0, 4'b1001, 1'b0, 4, 4'b0101, "op5");

    // Abort in IDLE is harmless
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abt_idle_unload", unload_data, 4'b0101);

    // Reset asserted during UNLOAD
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; load_data = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("rst2_in_unload", dbg_state, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst2_busy", busy, 0);
    check_eq("rst2_en", scan_en, 0);
    check_eq("rst2_in", scan_in, 0);
    check_eq("rst2_done", done, 0);
    check_eq("rst2_unload", unload_data, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst2_no_done", done_cnt - base, 0);
    check_eq("rst2_chain", c, 4'b0110);
    run_op(1'b0, 4'b1010, 1'b0, 4, 4'b0110, "op6");
    check_eq("op6_chain", c, 4'b1010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
